mcu_fsm: RTL
============

Name: mcu_fsm

Overview:
- Multi-cycle main controller for the MIPS core.
- Sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback states.
- Inserts memory wait states from a ready handshake.
- Emits the same `aluop` encoding consumed by `alu_cu`: 00 signed add, 01 signed sub, 10 unsigned add, 11 RR/funct.

Parameters:
- WAIT_LIMIT, 0, maximum consecutive `mem_ready`-low cycles in one memory state; 0 disables the timeout.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_we  out  1  PC write enable
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- ir_we  out  1  instruction register write
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- reg_we  out  1  register file write
- wreg_dst_sel  out  1  write-register select: 1 rd, 0 rt
- wrbck_sel  out  1  writeback select: 1 memory data, 0 ALUOut
- alusrca  out  1  ALU A select: 0 PC, 1 rs
- alusrcb  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- aluop  out  2  to `alu_cu`
- retire  out  1  1-cycle pulse in the final cycle of each instruction
- state_o  out  4  current state encoding, for debug
- mem_timeout  out  1  sticky timeout flag

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11, TRAP=12.
- Reset: state=FETCH, wait counter=0, mem_timeout=0. While rst_n=0, pc_we, ir_we, mem_rd, mem_wr, reg_we and retire are forced to 0. Reset asserted mid-instruction abandons it; no partial register or memory write follows.
- Outputs are decoded from state; unlisted outputs are 0.
  - FETCH: mem_rd=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pc_src=00; ir_we=pc_we=mem_ready.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: mem_rd=1, iord=1.
  - MEMWB: reg_we=1, wreg_dst_sel=0, wrbck_sel=1, retire=1.
  - MEMWR: mem_wr=1, iord=1, retire=mem_ready.
  - EXEC: alusrca=1, alusrcb=00, aluop=11.
  - ALUWB: reg_we=1, wreg_dst_sel=1, wrbck_sel=0, retire=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pc_src=01, pc_we=zero, retire=1.
  - IMMEXEC: alusrca=1, alusrcb=10; aluop=10 if opcode=ADDIU (001001), else 00.
  - IMMWB: reg_we=1, wreg_dst_sel=0, wrbck_sel=0, retire=1.
  - JUMP: pc_src=10, pc_we=1, retire=1.
- Transitions:
  - FETCH→DECODE when mem_ready=1, else hold.
  - DECODE on opcode:
    - LW 100011 / SW 101011→MEMADR
    - RR 000000→EXEC
    - BEQ 000100→BRANCH
    - ADDI 001000 / ADDIU 001001→IMMEXEC
    - J 000010→JUMP
    - any other opcode→FETCH, with no side effects and no retire.
  - MEMADR→MEMRD for LW, MEMWR for SW.
  - MEMRD→MEMWB on mem_ready, else hold.
  - MEMWR→FETCH on mem_ready, else hold.
  - EXEC→ALUWB; IMMEXEC→IMMWB.
  - MEMWB, ALUWB, IMMWB, BRANCH, JUMP→FETCH.
- Latency with mem_ready constantly 1: LW 5, SW 4, RR 4, ADDI/ADDIU 4, BEQ 3, J 3 cycles. Each low-ready cycle adds 1.
- Wait counter (WAIT_LIMIT>0):
  - Counts consecutive cycles with mem_ready=0 in FETCH, MEMRD or MEMWR.
  - Clears on mem_ready=1 and on any state change.
  - When it reaches WAIT_LIMIT: next state=FETCH, mem_timeout sets (sticky until reset), no retire, and no strobe other than the ongoing mem_rd/mem_wr is issued.
  - With WAIT_LIMIT=0 the block waits forever.
- A mem_ready arriving in the same cycle the counter hits the limit wins: the access completes normally.

Optional Feature:
- Macro: MCU_FSM_ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to TRAP.
  - TRAP holds forever (only reset exits) with all strobes 0.
  - Extra output port `illegal` (1 bit) reads 1 while in TRAP.
- Undefined: unrecognised opcode returns to FETCH as a no-op; there is no TRAP state and no `illegal` port.

Test Plan:
- Reset: assert rst_n=0 mid-MEMWR with mem_wr=1 → mem_wr drops to 0 immediately; after release state_o=0 and mem_timeout=0.
- LW with mem_ready=1: visits states 0,1,2,3,4 → reg_we=1, wrbck_sel=1, wreg_dst_sel=0 and retire=1 in cycle 5 only.
- BEQ: zero=1 → pc_we=1 and pc_src=01 in state 8; repeat with zero=0 → pc_we=0. Both take 3 cycles.
- ADDIU: opcode 001001 → aluop=10 in IMMEXEC; ADDI gives aluop=00; RR gives aluop=11 in EXEC and wreg_dst_sel=1 in ALUWB.
- Wait states: SW with mem_ready low 3 cycles in MEMWR → mem_wr held 4 cycles, retire on the ready cycle, 7 cycles total.
- Timeout (WAIT_LIMIT=4): mem_ready=0 in FETCH → after 4 cycles returns to FETCH with mem_timeout=1; flag persists through a later normal RR instruction. Opcode 111111 → returns to FETCH, or TRAP with illegal=1 when the macro is defined.

Source files
------------

// File: rtl/mcu_fsm.sv
// mcu_fsm: multi-cycle MIPS main controller sequencing fetch/decode/execute/memory/writeback.
// Optional: define MCU_FSM_ILLEGAL_TRAP_EN to park unrecognised opcodes in TRAP and expose `illegal`.
module mcu_fsm #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       wreg_dst_sel,
  output logic       wrbck_sel,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       retire,
  output logic [3:0] state_o,
  output logic       mem_timeout
`ifdef MCU_FSM_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [5:0] OP_RR    = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
`ifdef MCU_FSM_ILLEGAL_TRAP_EN
    ,
    TRAP    = 4'd12
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_timeout;
  logic            w_mem_state;
  logic            w_timeout;

  assign w_mem_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);

  // The limit is hit on the WAIT_LIMIT-th consecutive low cycle; a ready in that cycle still completes.
  assign w_timeout = (WAIT_LIMIT > 0) && w_mem_state && !mem_ready &&
                     (r_wait_cnt == CW'(WAIT_LIMIT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
      if ((WAIT_LIMIT > 0) && w_mem_state && !mem_ready && !w_timeout && (w_next == r_state)) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:      w_next = MEMADR;
          OP_RR:             w_next = EXEC;
          OP_BEQ:            w_next = BRANCH;
          OP_ADDI, OP_ADDIU: w_next = IMMEXEC;
          OP_J:              w_next = JUMP;
          default: begin
`ifdef MCU_FSM_ILLEGAL_TRAP_EN
            w_next = TRAP;
`else
            w_next = FETCH;
`endif
          end
        endcase
      end
      MEMADR:  w_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) w_next = MEMWB;
      MEMWR:   if (mem_ready) w_next = FETCH;
      EXEC:    w_next = ALUWB;
      IMMEXEC: w_next = IMMWB;
      MEMWB, ALUWB, IMMWB, BRANCH, JUMP: w_next = FETCH;
`ifdef MCU_FSM_ILLEGAL_TRAP_EN
      TRAP:    w_next = TRAP;
`endif
      default: w_next = FETCH;
    endcase
    if (w_timeout) begin
      w_next = FETCH;
    end
  end

  always_comb begin
    // NOTE: every output is defaulted before the case so no path through it infers a latch.
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    ir_we        = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_we       = 1'b0;
    wreg_dst_sel = 1'b0;
    wrbck_sel    = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    retire       = 1'b0;
    case (r_state)
      FETCH: begin
        mem_rd  = 1'b1;
        alusrcb = 2'b01;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        reg_we    = 1'b1;
        wrbck_sel = 1'b1;
        retire    = 1'b1;
      end
      MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        retire = mem_ready;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b11;
      end
      ALUWB: begin
        reg_we       = 1'b1;
        wreg_dst_sel = 1'b1;
        retire       = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pc_src  = 2'b01;
        pc_we   = zero;
        retire  = 1'b1;
      end
      IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (opcode == OP_ADDIU) ? 2'b10 : 2'b00;
      end
      IMMWB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
    // Strobes go quiet combinationally while reset is held, independent of the state register.
    if (!rst_n) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      reg_we = 1'b0;
      retire = 1'b0;
    end
  end

  assign state_o     = r_state;
  assign mem_timeout = r_timeout;
`ifdef MCU_FSM_ILLEGAL_TRAP_EN
  assign illegal     = (r_state == TRAP);
`endif

endmodule
